// File: rtl/switch_debouncer.sv
// Debounces 16 board switches with a shared tick prescaler and per-bit stability
// counters; reports debounced changes as a one-cycle pulse and a level IRQ.
module switch_debouncer #(
  parameter int TICK_DIV     = 100000,
  parameter int STABLE_COUNT = 10
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] SW_RAW,
  input  logic        IRQ_ACK,
  output logic [7:0]  SWH,
  output logic [7:0]  SWL,
  output logic        SW_CHANGED,
  output logic        IRQ_RAISE
);

  localparam int              PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [3:0]      RUN_LAST  = 4'(STABLE_COUNT - 1);

  logic [15:0]   sync_p0;
  logic [15:0]   sync_p1;
  logic [PW-1:0] presc;
  logic          tick;
  logic [3:0]    run_cnt [16];
  logic [3:0]    run_nxt [16];
  logic [15:0]   deb;
  logic [15:0]   deb_nxt;
  logic [15:0]   accept;

  assign tick = (presc == TICK_LAST);

  // Stage p1 -> debounce decision: runs of differing ticks promote the synced level
  always_comb begin
    deb_nxt = deb;
    accept  = '0;
    for (int i = 0; i < 16; i++) begin
      run_nxt[i] = run_cnt[i];
      if (tick) begin
        if (sync_p1[i] == deb[i]) begin
          run_nxt[i] = '0;
        end else if (run_cnt[i] == RUN_LAST) begin
          deb_nxt[i] = sync_p1[i];
          accept[i]  = 1'b1;
          run_nxt[i] = '0;
        end else begin
          run_nxt[i] = run_cnt[i] + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync_p0    <= '0;
      sync_p1    <= '0;
      presc      <= '0;
      deb        <= '0;
      SW_CHANGED <= 1'b0;
      IRQ_RAISE  <= 1'b0;
      for (int i = 0; i < 16; i++) run_cnt[i] <= '0;
    end else begin
      sync_p0    <= SW_RAW;
      sync_p1    <= sync_p0;
      presc      <= tick ? '0 : presc + PW'(1);
      deb        <= deb_nxt;
      SW_CHANGED <= |accept;
      // A new change wins over a coincident acknowledge
      IRQ_RAISE  <= SW_CHANGED | (IRQ_RAISE & ~IRQ_ACK);
      for (int i = 0; i < 16; i++) run_cnt[i] <= run_nxt[i];
    end
  end

  assign SWH = deb[15:8];
  assign SWL = deb[7:0];

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer: two instances (4/3 and 2/1) share stimulus and are
// checked against a tick-sample history model of the debounce rules.
module tb_switch_debouncer;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        IRQ_ACK;
  logic [15:0] SW_RAW;
  logic [1:0][7:0] swh;
  logic [1:0][7:0] swl;
  logic [1:0]      chg_o;
  logic [1:0]      irq_o;

  int compared   = 0;
  int mismatched = 0;

  always #5 CLK = ~CLK;

  switch_debouncer #(.TICK_DIV(4), .STABLE_COUNT(3)) dut0 (
    .CLK(CLK), .RESET(RESET), .SW_RAW(SW_RAW), .IRQ_ACK(IRQ_ACK),
    .SWH(swh[0]), .SWL(swl[0]), .SW_CHANGED(chg_o[0]), .IRQ_RAISE(irq_o[0])
  );

  switch_debouncer #(.TICK_DIV(2), .STABLE_COUNT(1)) dut1 (
    .CLK(CLK), .RESET(RESET), .SW_RAW(SW_RAW), .IRQ_ACK(IRQ_ACK),
    .SWH(swh[1]), .SWL(swl[1]), .SW_CHANGED(chg_o[1]), .IRQ_RAISE(irq_o[1])
  );

  // Reference model: raw values reach the debouncer two edges late; a bit is
  // accepted when the last STABLE_COUNT tick samples all disagree with it.
  logic [15:0] rawq[$];
  int          n    [2];
  int          hcnt [2];
  logic [15:0] hist [2][16];
  logic [15:0] mdb  [2];
  logic        mchg [2];
  logic        mirq [2];

  function automatic int td(input int d);
    return (d == 0) ? 4 : 2;
  endfunction

  function automatic int sc(input int d);
    return (d == 0) ? 3 : 1;
  endfunction

  function automatic void model_update(input logic [15:0] r, input logic rst, input logic ack);
    logic [15:0] smp;
    logic [15:0] dm;
    if (rst) begin
      rawq = '{16'h0, 16'h0};
      for (int d = 0; d < 2; d++) begin
        n[d] = 0; hcnt[d] = 0; mdb[d] = '0; mchg[d] = 1'b0; mirq[d] = 1'b0;
      end
    end else begin
      smp = rawq[0];
      for (int d = 0; d < 2; d++) begin
        mirq[d] = mchg[d] ? 1'b1 : (ack ? 1'b0 : mirq[d]);
        dm = '0;
        if ((n[d] % td(d)) == td(d) - 1) begin
          for (int k = 15; k > 0; k--) hist[d][k] = hist[d][k-1];
          hist[d][0] = smp;
          if (hcnt[d] < sc(d)) hcnt[d]++;
          if (hcnt[d] == sc(d)) begin
            dm = '1;
            for (int k = 0; k < sc(d); k++) dm &= hist[d][k] ^ mdb[d];
          end
          mdb[d] ^= dm;
        end
        mchg[d] = |dm;
        n[d]++;
      end
      rawq.push_back(r);
      void'(rawq.pop_front());
    end
  endfunction

  task automatic step(input logic [15:0] r, input logic rst, input logic ack);
    SW_RAW = r; RESET = rst; IRQ_ACK = ack;
    @(posedge CLK);
    model_update(r, rst, ack);
    #1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) step(16'hFFFF, 1'b1, 1'b1);
    for (int d = 0; d < 2; d++) begin
      compared++;
      if ({swh[d], swl[d], chg_o[d], irq_o[d]} !== 18'd0) begin
        mismatched++;
        $display("FAIL reset dut%0d: got %h want %h", d, {swh[d], swl[d], chg_o[d], irq_o[d]}, 18'd0);
      end
    end
  endtask

  task automatic test_single_bit();
    int first[2];
    int pulses0;
    first = '{0, 0}; pulses0 = 0;
    step(16'h0000, 1'b1, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      step(16'h0001, 1'b0, 1'b0);
      for (int d = 0; d < 2; d++) begin
        compared++;
        if ({swh[d], swl[d], chg_o[d], irq_o[d]} !== {mdb[d], mchg[d], mirq[d]}) begin
          mismatched++;
          $display("FAIL single_bit dut%0d cyc%0d: got %h want %h", d, i,
                   {swh[d], swl[d], chg_o[d], irq_o[d]}, {mdb[d], mchg[d], mirq[d]});
        end
        if (chg_o[d] && first[d] == 0) first[d] = i;
      end
      if (chg_o[0]) pulses0++;
    end
    compared++;
    if (first[0] != 12) begin
      mismatched++; $display("FAIL single_bit_latency dut0: got %0d want 12", first[0]);
    end
    compared++;
    if (first[1] != 4) begin
      mismatched++; $display("FAIL single_bit_latency dut1: got %0d want 4", first[1]);
    end
    compared++;
    if (pulses0 != 1 || swl[0] !== 8'h01 || irq_o[0] !== 1'b1) begin
      mismatched++;
      $display("FAIL single_bit_final dut0: got pulses=%0d swl=%h irq=%b want 1 01 1", pulses0, swl[0], irq_o[0]);
    end
  endtask

  task automatic test_glitch();
    int pulses0;
    logic [15:0] r;
    pulses0 = 0;
    step(16'h0000, 1'b1, 1'b0);
    for (int i = 0; i < 38; i++) begin
      r = (i >= 4 && i < 8) ? 16'h0200 : 16'h0000;
      step(r, 1'b0, 1'b0);
      for (int d = 0; d < 2; d++) begin
        compared++;
        if ({swh[d], swl[d], chg_o[d], irq_o[d]} !== {mdb[d], mchg[d], mirq[d]}) begin
          mismatched++;
          $display("FAIL glitch dut%0d cyc%0d: got %h want %h", d, i,
                   {swh[d], swl[d], chg_o[d], irq_o[d]}, {mdb[d], mchg[d], mirq[d]});
        end
      end
      if (chg_o[0]) pulses0++;
    end
    compared++;
    if (pulses0 != 0 || swh[0] !== 8'h00 || irq_o[0] !== 1'b0) begin
      mismatched++;
      $display("FAIL glitch_final dut0: got pulses=%0d swh=%h irq=%b want 0 00 0", pulses0, swh[0], irq_o[0]);
    end
  endtask

  task automatic test_multi_bit();
    int pulses0;
    pulses0 = 0;
    step(16'h0000, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(16'hA55A, 1'b0, 1'b0);
      for (int d = 0; d < 2; d++) begin
        compared++;
        if ({swh[d], swl[d], chg_o[d], irq_o[d]} !== {mdb[d], mchg[d], mirq[d]}) begin
          mismatched++;
          $display("FAIL multi_bit dut%0d cyc%0d: got %h want %h", d, i,
                   {swh[d], swl[d], chg_o[d], irq_o[d]}, {mdb[d], mchg[d], mirq[d]});
        end
      end
      if (chg_o[0]) begin
        pulses0++;
        compared++;
        if ({swh[0], swl[0]} !== 16'hA55A) begin
          mismatched++; $display("FAIL multi_bit_same_cycle dut0: got %h want a55a", {swh[0], swl[0]});
        end
      end
    end
    compared++;
    if (pulses0 != 1) begin
      mismatched++; $display("FAIL multi_bit_pulses dut0: got %0d want 1", pulses0);
    end
  endtask

  task automatic test_irq_collision();
    bit seen;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step(16'h0000, 1'b0, 1'b0);
      if (mchg[0]) seen = 1;
    end
    compared++;
    if (!seen || chg_o[0] !== 1'b1 || irq_o[0] !== 1'b1) begin
      mismatched++;
      $display("FAIL irq_setup dut0: got seen=%0d chg=%b irq=%b want 1 1 1", seen, chg_o[0], irq_o[0]);
    end
    step(16'h0000, 1'b0, 1'b1);
    compared++;
    if (irq_o[0] !== 1'b1) begin
      mismatched++; $display("FAIL irq_set_wins dut0: got %b want 1", irq_o[0]);
    end
    step(16'h0000, 1'b0, 1'b0);
    step(16'h0000, 1'b0, 1'b1);
    compared++;
    if (irq_o[0] !== 1'b0) begin
      mismatched++; $display("FAIL irq_ack_clears dut0: got %b want 0", irq_o[0]);
    end
    for (int d = 0; d < 2; d++) begin
      compared++;
      if ({swh[d], swl[d], chg_o[d], irq_o[d]} !== {mdb[d], mchg[d], mirq[d]}) begin
        mismatched++;
        $display("FAIL irq_model dut%0d: got %h want %h", d,
                 {swh[d], swl[d], chg_o[d], irq_o[d]}, {mdb[d], mchg[d], mirq[d]});
      end
    end
  endtask

  task automatic test_reset_mid();
    int first[2];
    first = '{0, 0};
    step(16'h0000, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) step(16'h0004, 1'b0, 1'b0);
    step(16'h0004, 1'b1, 1'b0);
    compared++;
    if ({swh[0], swl[0], chg_o[0], irq_o[0]} !== 18'd0) begin
      mismatched++; $display("FAIL reset_mid_outputs dut0: got %h want 0", {swh[0], swl[0], chg_o[0], irq_o[0]});
    end
    for (int i = 1; i <= 16; i++) begin
      step(16'h0004, 1'b0, 1'b0);
      for (int d = 0; d < 2; d++) begin
        compared++;
        if ({swh[d], swl[d], chg_o[d], irq_o[d]} !== {mdb[d], mchg[d], mirq[d]}) begin
          mismatched++;
          $display("FAIL reset_mid dut%0d cyc%0d: got %h want %h", d, i,
                   {swh[d], swl[d], chg_o[d], irq_o[d]}, {mdb[d], mchg[d], mirq[d]});
        end
        if (chg_o[d] && first[d] == 0) first[d] = i;
      end
    end
    compared++;
    if (first[0] != 12 || first[1] != 4) begin
      mismatched++; $display("FAIL reset_mid_latency: got %0d/%0d want 12/4", first[0], first[1]);
    end
  endtask

  task automatic test_random();
    logic [15:0] r;
    logic        rst, ack;
    r = 16'h0000;
    step(r, 1'b1, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 15))
        0:       r = 16'($urandom);
        1, 2:    r ^= 16'(1) << $urandom_range(0, 15);
        default: ;
      endcase
      ack = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 499) == 0);
      step(r, rst, ack);
      for (int d = 0; d < 2; d++) begin
        compared++;
        if ({swh[d], swl[d], chg_o[d], irq_o[d]} !== {mdb[d], mchg[d], mirq[d]}) begin
          mismatched++;
          $display("FAIL random dut%0d cyc%0d: got %h want %h", d, i,
                   {swh[d], swl[d], chg_o[d], irq_o[d]}, {mdb[d], mchg[d], mirq[d]});
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    SW_RAW = '0; RESET = 1'b1; IRQ_ACK = 1'b0;
    test_reset();
    test_single_bit();
    test_glitch();
    test_multi_bit();
    test_irq_collision();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/switch_debouncer.md
SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

Interface
REQ-001 Parameter TICK_DIV, default 100000, meaning clock cycles per debounce sample tick (1 ms at 100 MHz); legal range 2..2^20.
REQ-002 Parameter STABLE_COUNT, default 10, meaning consecutive ticks a new level must persist before acceptance; legal range 1..15.
REQ-003 CLK  input  1  system clock; one clock domain, all state updates on rising edge.
REQ-004 RESET  input  1  synchronous active-high reset, sampled on the CLK rising edge.
REQ-005 SW_RAW  input  16  asynchronous raw board switch levels; bit 15..8 high byte, bit 7..0 low byte.
REQ-006 SWH  output  8  debounced switches 15..8, registered; feeds the bus switches peripheral high byte.
REQ-007 SWL  output  8  debounced switches 7..0, registered; feeds the bus switches peripheral low byte.
REQ-008 SW_CHANGED  output  1  one-cycle pulse, high in the cycle SWH/SWL first show a new value.
REQ-009 IRQ_RAISE  output  1  level interrupt request to the processor, set on any debounced change.
REQ-010 IRQ_ACK  input  1  interrupt acknowledge from the processor, single-cycle pulse.

Function
REQ-011 Each SW_RAW bit SHALL pass through a two-flop synchronizer; only the second flop output (sync bit) is used downstream.
REQ-012 A prescaler SHALL count 0..TICK_DIV-1 and wrap to 0; TICK SHALL be high for exactly the one cycle in which the count equals TICK_DIV-1.
REQ-013 Each of the 16 bits SHALL own a 4-bit stability counter; counters update only when TICK is high.
REQ-014 On TICK, if sync bit equals its debounced bit, the bit's counter SHALL clear to 0.
REQ-015 On TICK, if sync bit differs and counter equals STABLE_COUNT-1, the debounced bit SHALL take the sync value and the counter SHALL clear to 0.
REQ-016 On TICK, if sync bit differs and counter is below STABLE_COUNT-1, the counter SHALL increment by 1.
REQ-017 A glitch that returns before acceptance SHALL clear that counter on the next TICK and leave the debounced bit unchanged.
REQ-018 With STABLE_COUNT=1, a differing sync bit SHALL be accepted on the first TICK that sees it.
REQ-019 Bits SHALL debounce independently; several bits may update in the same cycle.
REQ-020 SW_CHANGED SHALL be registered so it is high in the same cycle as the updated SWH/SWL value and low otherwise, including when several bits change at once.
REQ-021 IRQ_RAISE SHALL set on the cycle after SW_CHANGED is high and clear on the cycle after IRQ_ACK is high.
REQ-022 If a set condition and IRQ_ACK coincide in the same cycle, IRQ_RAISE SHALL end that cycle set (set wins).
REQ-023 IRQ_ACK while IRQ_RAISE is low SHALL have no effect.
REQ-024 Latency from a clean raw edge to SWH/SWL update SHALL be 2 sync cycles plus STABLE_COUNT ticks, i.e. at most 2 + STABLE_COUNT*TICK_DIV + 1 cycles.

Reset
REQ-025 While RESET is high: synchronizer flops, prescaler, all stability counters, SWH, SWL, SW_CHANGED and IRQ_RAISE SHALL be 0 on the next edge.
REQ-026 RESET asserted mid-debounce SHALL discard partial counts; after release, raw switches held high SHALL need the full STABLE_COUNT ticks.
REQ-027 The first TICK after reset release SHALL occur TICK_DIV cycles after the first edge with RESET low.
REQ-028 Switches already high at reset release SHALL produce a normal debounced change, SW_CHANGED pulse and IRQ_RAISE.

Verification (TICK_DIV=4, STABLE_COUNT=3)
REQ-029 SW_RAW=16'h0001 held from reset release -> SWL=8'h01 after exactly 3 ticks (about 12-14 cycles), one SW_CHANGED pulse, IRQ_RAISE=1 next cycle.
REQ-030 SW_RAW bit 9 toggles for 1 tick then returns -> SWH stays 8'h00, no SW_CHANGED, IRQ_RAISE stays 0.
REQ-031 SW_RAW=16'hA55A applied at once -> SWH=8'hA5 and SWL=8'h5A update in the same cycle, with a single SW_CHANGED pulse.
REQ-032 IRQ_RAISE=1, IRQ_ACK pulsed in the same cycle as a new SW_CHANGED -> IRQ_RAISE remains 1; a later lone IRQ_ACK clears it.
REQ-033 RESET pulsed after 2 of 3 ticks on a rising bit -> outputs 0; the bit is accepted only after 3 further ticks.
REQ-034 TICK_DIV=2, STABLE_COUNT=1 -> a bit change is accepted on the first tick after sync, and the prescaler wraps every 2 cycles.
